// File: rtl/pulse_spacer_if.sv
// pulse_spacer_if: per-channel event request / pulse response bundle.
// master = upstream event source, slave = pulse_spacer.
interface pulse_spacer_if #(
    parameter int CHANNELS = 1
);
    logic [CHANNELS-1:0] pulse_in;
    logic [CHANNELS-1:0] pulse_out;
    logic [CHANNELS-1:0] busy;
    logic [CHANNELS-1:0] overflow;
    logic [CHANNELS-1:0] overflow_clear;

    modport master (
        output pulse_in,
        output overflow_clear,
        input  pulse_out,
        input  busy,
        input  overflow
    );

    modport slave (
        input  pulse_in,
        input  overflow_clear,
        output pulse_out,
        output busy,
        output overflow
    );
endinterface

// File: rtl/pulse_spacer.sv
// pulse_spacer: per-channel event queue replayed as spaced pulses.
// Optional sticky drop flag: define PULSE_SPACER_OVERFLOW_EN.
module pulse_spacer #(
    parameter int CHANNELS            = 1,
    parameter int PULSE_COUNTER_WIDTH = 3,
    parameter int HIGH_CYCLES         = 1,
    parameter int LOW_CYCLES          = 1
) (
    input  logic          clock,
    input  logic          resetn,
    pulse_spacer_if.slave bus
);
    localparam int W = PULSE_COUNTER_WIDTH;
    localparam int PH_MAX =
        (HIGH_CYCLES > LOW_CYCLES) ? HIGH_CYCLES : LOW_CYCLES;
    localparam int PW = $clog2(PH_MAX + 1);

    localparam logic [W-1:0]  PEND_MAX = '1;
    localparam logic [PW-1:0] HI_LAST  = PW'(HIGH_CYCLES - 1);
    localparam logic [PW-1:0] LO_LAST  = PW'(LOW_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_HIGH,
        S_LOW
    } state_t;

    logic [CHANNELS-1:0] pulse_vec;
    logic [CHANNELS-1:0] busy_vec;
    logic [CHANNELS-1:0] drop_vec;

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        state_t         state_q;
        state_t         state_d;
        logic [W-1:0]   pend_q;
        logic [W-1:0]   pend_d;
        logic [PW-1:0]  phase_q;
        logic [PW-1:0]  phase_d;
        logic           pulse_q;
        logic           busy_q;
        logic           req;
        logic           full;
        logic           last_high;
        logic           last_low;
        logic           start;
        logic           inc;
        logic           dec;
        logic           drop;

        assign req       = bus.pulse_in[c];
        assign full      = (pend_q == PEND_MAX);
        assign last_high = (phase_q == HI_LAST);
        assign last_low  = (phase_q == LO_LAST);

        // A new pulse may begin from IDLE or in the closing LOW cycle,
        // and an arriving event can be consumed by that same start.
        always_comb begin
            start = 1'b0;
            if ((state_q == S_IDLE) ||
                (state_q == S_LOW && last_low)) begin
                start = (pend_q != '0) || req;
            end
        end

        assign inc  = req && (!full || start);
        assign dec  = start;
        assign drop = req && full && !start;

        always_comb begin
            pend_d = pend_q;
            if (inc && !dec) begin
                pend_d = pend_q + 1'b1;
            end else if (dec && !inc) begin
                pend_d = pend_q - 1'b1;
            end
        end

        always_comb begin
            state_d = state_q;
            phase_d = phase_q;
            unique case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_d = S_HIGH;
                        phase_d = '0;
                    end
                end
                S_HIGH: begin
                    if (last_high) begin
                        state_d = S_LOW;
                        phase_d = '0;
                    end else begin
                        phase_d = phase_q + 1'b1;
                    end
                end
                S_LOW: begin
                    if (last_low) begin
                        state_d = start ? S_HIGH : S_IDLE;
                        phase_d = '0;
                    end else begin
                        phase_d = phase_q + 1'b1;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    phase_d = '0;
                end
            endcase
        end

        always_ff @(posedge clock or negedge resetn) begin
            if (!resetn) begin
                state_q <= S_IDLE;
                pend_q  <= '0;
                phase_q <= '0;
                pulse_q <= 1'b0;
                busy_q  <= 1'b0;
            end else begin
                state_q <= state_d;
                pend_q  <= pend_d;
                phase_q <= phase_d;
                pulse_q <= (state_d == S_HIGH);
                busy_q  <= (pend_d == PEND_MAX);
            end
        end

        assign pulse_vec[c] = pulse_q;
        assign busy_vec[c]  = busy_q;
        assign drop_vec[c]  = drop;
    end

    assign bus.pulse_out = pulse_vec;
    assign bus.busy      = busy_vec;

`ifdef PULSE_SPACER_OVERFLOW_EN
    logic [CHANNELS-1:0] ovf_q;

    // A drop in the same cycle beats a clear request.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            ovf_q <= '0;
        end else begin
            ovf_q <= drop_vec | (ovf_q & ~bus.overflow_clear);
        end
    end

    assign bus.overflow = ovf_q;
`else
    logic unused_ovf;

    assign unused_ovf   = ^{bus.overflow_clear, drop_vec};
    assign bus.overflow = '0;
`endif

endmodule

// File: tb/tb_pulse_spacer.sv
// tb_pulse_spacer: scoreboard bench, two DUTs (1/1 and 3/2 timing).
// Lanes 0-1 are DUT a, lanes 2-3 are DUT b.
module tb_pulse_spacer;
    localparam int CH   = 2;
    localparam int W    = 3;
    localparam int MAXP = 7;
    localparam int NL   = 4;

    logic clock  = 1'b0;
    logic resetn = 1'b0;

    always #5 clock = ~clock;

    pulse_spacer_if #(.CHANNELS(CH)) bus_a ();
    pulse_spacer_if #(.CHANNELS(CH)) bus_b ();

    pulse_spacer #(
        .CHANNELS(CH),
        .PULSE_COUNTER_WIDTH(W),
        .HIGH_CYCLES(1),
        .LOW_CYCLES(1)
    ) u_a (
        .clock(clock),
        .resetn(resetn),
        .bus(bus_a.slave)
    );

    pulse_spacer #(
        .CHANNELS(CH),
        .PULSE_COUNTER_WIDTH(W),
        .HIGH_CYCLES(3),
        .LOW_CYCLES(2)
    ) u_b (
        .clock(clock),
        .resetn(resetn),
        .bus(bus_b.slave)
    );

    logic [NL-1:0] pin, pout, bsy, ovf, clr;

    assign pin  = {bus_b.pulse_in, bus_a.pulse_in};
    assign pout = {bus_b.pulse_out, bus_a.pulse_out};
    assign bsy  = {bus_b.busy, bus_a.busy};
    assign ovf  = {bus_b.overflow, bus_a.overflow};
    assign clr  = {bus_b.overflow_clear, bus_a.overflow_clear};

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(string tag, logic [31:0] got,
                       logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    function automatic int hi_of(int l);
        return (l < 2) ? 1 : 3;
    endfunction

    function automatic int lo_of(int l);
        return (l < 2) ? 1 : 2;
    endfunction

    // Reference: an event at edge N starts at max(N, prev + H + L);
    // it is accepted while fewer than MAXP starts lie beyond N.
    int edge_n = 0;
    int fut[NL][$];
    int sb[NL][$];
    int last_s[NL];
    int n_acc[NL];
    bit exp_out[NL];
    bit exp_busy[NL];
    bit exp_ovf[NL];

    int m_h, m_g, m_cnt, m_s;
    bit m_drop;

    always @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            for (int l = 0; l < NL; l++) begin
                fut[l].delete();
                sb[l].delete();
                last_s[l]   = -1000;
                n_acc[l]    = 0;
                exp_out[l]  = 1'b0;
                exp_busy[l] = 1'b0;
                exp_ovf[l]  = 1'b0;
            end
        end else begin
            edge_n++;
            for (int l = 0; l < NL; l++) begin
                m_h = hi_of(l);
                m_g = m_h + lo_of(l);
                while (fut[l].size() > 0 &&
                       fut[l][0] + m_h <= edge_n)
                    void'(fut[l].pop_front());
                m_cnt = 0;
                for (int j = 0; j < fut[l].size(); j++)
                    if (fut[l][j] > edge_n) m_cnt++;
                m_drop = 1'b0;
                if (pin[l]) begin
                    if (m_cnt < MAXP) begin
                        m_s = last_s[l] + m_g;
                        if (m_s < edge_n) m_s = edge_n;
                        fut[l].push_back(m_s);
                        sb[l].push_back(m_s);
                        last_s[l] = m_s;
                        n_acc[l]++;
                    end else begin
                        m_drop = 1'b1;
                    end
                end
                m_cnt = 0;
                exp_out[l] = 1'b0;
                for (int j = 0; j < fut[l].size(); j++) begin
                    if (fut[l][j] > edge_n) m_cnt++;
                    if (fut[l][j] <= edge_n &&
                        edge_n < fut[l][j] + m_h)
                        exp_out[l] = 1'b1;
                end
                exp_busy[l] = (m_cnt == MAXP);
`ifdef PULSE_SPACER_OVERFLOW_EN
                if (m_drop) exp_ovf[l] = 1'b1;
                else if (clr[l]) exp_ovf[l] = 1'b0;
`else
                exp_ovf[l] = 1'b0;
`endif
            end
        end
    end

    bit prev[NL];
    int n_out[NL];

    always @(negedge clock) begin
        for (int l = 0; l < NL; l++) begin
            chk($sformatf("pulse_out[%0d]@%0d", l, edge_n),
                pout[l], exp_out[l]);
            chk($sformatf("busy[%0d]@%0d", l, edge_n),
                bsy[l], exp_busy[l]);
            chk($sformatf("overflow[%0d]@%0d", l, edge_n),
                ovf[l], exp_ovf[l]);
            if (!resetn) begin
                prev[l]  = 1'b0;
                n_out[l] = 0;
            end else begin
                if (pout[l] && !prev[l]) begin
                    n_out[l]++;
                    if (sb[l].size() == 0)
                        chk($sformatf("start[%0d]", l), edge_n, -1);
                    else
                        chk($sformatf("start[%0d]", l), edge_n,
                            sb[l].pop_front());
                end
                prev[l] = pout[l];
            end
        end
    end

    int snap[NL];

    task automatic step(int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic take_snap();
        for (int l = 0; l < NL; l++) snap[l] = n_out[l];
    endtask

    function automatic int delta(int l);
        return n_out[l] - snap[l];
    endfunction

    initial begin
        bus_a.pulse_in       = '0;
        bus_a.overflow_clear = '0;
        bus_b.pulse_in       = '0;
        bus_b.overflow_clear = '0;
        resetn = 1'b0;
        step(3);
        chk("rst pulse_out", pout, 0);
        chk("rst busy", bsy, 0);
        chk("rst overflow", ovf, 0);
        resetn = 1'b1;
        step(2);

        take_snap();
        bus_a.pulse_in = 2'b01;
        step(1);
        bus_a.pulse_in = 2'b00;
        step(6);
        chk("t1 pulses ch0", delta(0), 1);
        chk("t1 pulses ch1", delta(1), 0);

        take_snap();
        bus_a.pulse_in = 2'b01;
        step(4);
        bus_a.pulse_in = 2'b00;
        step(10);
        chk("t2 pulses ch0", delta(0), 4);
        chk("t2 busy", bus_a.busy, 0);

        take_snap();
        for (int i = 0; i < 4; i++) begin
            bus_a.pulse_in = 2'b11;
            step(1);
            bus_a.pulse_in = 2'b00;
            step(1);
        end
        step(6);
        chk("t3 pulses ch0", delta(0), 4);
        chk("t3 pulses ch1", delta(1), 4);

        take_snap();
        bus_a.pulse_in = 2'b01;
        step(13);
        chk("t4 busy pre", bus_a.busy[0], 0);
        step(1);
        chk("t4 busy rise", bus_a.busy[0], 1);
        step(6);
        bus_a.pulse_in = 2'b00;
        step(40);
        chk("t4 pulses ch0", delta(0), 17);
`ifdef PULSE_SPACER_OVERFLOW_EN
        chk("t4 overflow held", bus_a.overflow[0], 1);
`else
        chk("t4 overflow tied", bus_a.overflow[0], 0);
`endif
        bus_a.overflow_clear = 2'b01;
        step(1);
        bus_a.overflow_clear = 2'b00;
        step(1);
        chk("t4 overflow cleared", bus_a.overflow[0], 0);

        take_snap();
        bus_b.pulse_in = 2'b01;
        step(3);
        bus_b.pulse_in = 2'b00;
        step(20);
        chk("t5 pulses b0", delta(2), 3);
        chk("t5 pulses b1", delta(3), 0);

        for (int l = 0; l < NL; l++)
            chk($sformatf("total[%0d]", l), n_out[l], n_acc[l]);

        bus_a.pulse_in = 2'b01;
        step(11);
        bus_a.pulse_in = 2'b00;
        chk("t6 mid-pulse", bus_a.pulse_out[0], 1);
        #2;
        resetn = 1'b0;
        #1;
        chk("t6 rst pulse_out", pout, 0);
        chk("t6 rst busy", bsy, 0);
        chk("t6 rst overflow", ovf, 0);
        step(2);
        resetn = 1'b1;
        take_snap();
        step(15);
        chk("t6 quiet ch0", delta(0), 0);
        chk("t6 quiet ch1", delta(1), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end
endmodule
